// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the ADC result SPI slave.
package adc_pkg;

  localparam int unsigned CW_DEFAULT         = 24;
  localparam int unsigned FRAME_BITS         = 16 + 3 * CW_DEFAULT;
  localparam int unsigned STATUS_OVERRUN_BIT = 7;
  localparam int unsigned STATUS_SAT_BIT     = 6;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall detection on the
// synchronised level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 0 so a pin already low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = level & ~prev_q;
    fall  = ~level & prev_q;
  end

endmodule

// File: rtl/adc_result_spi.sv
// Captures multi-slope conversion counts into a stamped holding register and serves them
// to the host over an SPI mode-0 slave.
module adc_result_spi
  import adc_pkg::*;
#(
  parameter int unsigned CW          = CW_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          meas_valid,
  input  logic [CW-1:0] count_up,
  input  logic [CW-1:0] count_down,
  input  logic [CW-1:0] count_rundown,
  input  logic          spi_sck,
  input  logic          spi_cs_n,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic          data_ready
);

  localparam int unsigned FrameBits = 16 + 3 * CW;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);

  spi_state_e           state_q, state_d;
  logic [7:0]           seq_q, seq_d;
  logic [7:0]           hold_seq_q, hold_seq_d;
  logic [CW-1:0]        hold_up_q, hold_up_d;
  logic [CW-1:0]        hold_down_q, hold_down_d;
  logic [CW-1:0]        hold_rd_q, hold_rd_d;
  logic                 overrun_q, overrun_d;
  logic                 ready_q, ready_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;

  logic [FrameBits-1:0] frame;
  logic [7:0]           status;
  logic                 sat;
  logic                 sck_rise, sck_fall, cs_rise, cs_fall;
  logic                 unused_sck_level, unused_cs_level;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_sck),
    .level(unused_sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (spi_cs_n),
    .level(unused_cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_comb begin
    sat    = (hold_up_q == '1) | (hold_down_q == '1) | (hold_rd_q == '1);
    status = '0;
    status[STATUS_OVERRUN_BIT] = overrun_q;
    status[STATUS_SAT_BIT]     = sat;
    frame  = {hold_seq_q, status, hold_up_q, hold_down_q, hold_rd_q};
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    hold_seq_d  = hold_seq_q;
    hold_up_d   = hold_up_q;
    hold_down_d = hold_down_q;
    hold_rd_d   = hold_rd_q;
    overrun_d   = overrun_q;
    ready_d     = ready_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;

    unique case (state_q)
      StIdle: begin
        oe_d   = 1'b0;
        miso_d = 1'b0;
        if (cs_fall) state_d = StLoad;
      end
      StLoad: begin
        shift_d   = frame;
        bit_cnt_d = '0;
        ready_d   = 1'b0;
        overrun_d = 1'b0;
        oe_d      = 1'b1;
        miso_d    = frame[FrameBits-1];
        state_d   = StShift;
        if (cs_rise) begin
          state_d = StIdle;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d = StIdle;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end else begin
          if (sck_rise && (bit_cnt_q != CntW'(FrameBits))) bit_cnt_d = bit_cnt_q + 1'b1;
          if (sck_fall) begin
            shift_d = {shift_q[FrameBits-2:0], 1'b0};
            miso_d  = shift_q[FrameBits-2];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture after the LOAD clear so a new result in the LOAD cycle survives the read.
    if (meas_valid) begin
      hold_seq_d  = seq_q;
      hold_up_d   = count_up;
      hold_down_d = count_down;
      hold_rd_d   = count_rundown;
      seq_d       = seq_q + 8'd1;
      if (ready_q && (state_q != StLoad)) overrun_d = 1'b1;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      seq_q       <= '0;
      hold_seq_q  <= '0;
      hold_up_q   <= '0;
      hold_down_q <= '0;
      hold_rd_q   <= '0;
      overrun_q   <= 1'b0;
      ready_q     <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      hold_seq_q  <= hold_seq_d;
      hold_up_q   <= hold_up_d;
      hold_down_q <= hold_down_d;
      hold_rd_q   <= hold_rd_d;
      overrun_q   <= overrun_d;
      ready_q     <= ready_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign data_ready  = ready_q;

endmodule

// File: tb/tb_adc_result_spi.sv
// Bench for adc_result_spi: fixed vector table, randomized captures against a result model,
// and hand-built sequences for LOAD collision, abort, over-clocking and mid-transfer reset.
module tb_adc_result_spi;

  localparam int CW   = 24;
  localparam int FB   = 88;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          meas_valid = 1'b0;
  logic [CW-1:0] count_up = '0;
  logic [CW-1:0] count_down = '0;
  logic [CW-1:0] count_rundown = '0;
  logic          spi_sck = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_miso;
  logic          spi_miso_oe;
  logic          data_ready;

  always #5 clk = ~clk;

  adc_result_spi #(
    .CW         (CW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .meas_valid   (meas_valid),
    .count_up     (count_up),
    .count_down   (count_down),
    .count_rundown(count_rundown),
    .spi_sck      (spi_sck),
    .spi_cs_n     (spi_cs_n),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .data_ready   (data_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Result model: what the host should see, tracked as plain values.
  logic [7:0]    m_seq;
  logic [7:0]    h_seq;
  logic [CW-1:0] h_up, h_dn, h_rd;
  logic          m_ready, m_ovr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_seq = '0; h_seq = '0; h_up = '0; h_dn = '0; h_rd = '0; m_ready = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_capture(input logic [CW-1:0] u, input logic [CW-1:0] d,
                               input logic [CW-1:0] r);
    if (m_ready) m_ovr = 1'b1;
    h_seq = m_seq;
    m_seq = m_seq + 8'd1;
    h_up = u; h_dn = d; h_rd = r;
    m_ready = 1'b1;
  endtask

  task automatic model_read();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  function automatic logic [FB-1:0] model_frame();
    logic sat;
    sat = (h_up == '1) || (h_dn == '1) || (h_rd == '1);
    return {h_seq, m_ovr, sat, 6'b0, h_up, h_dn, h_rd};
  endfunction

  function automatic logic [CW-1:0] rnd_count();
    if ($urandom_range(0, 5) == 0) return '1;
    return CW'($urandom);
  endfunction

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic capture(input logic [CW-1:0] u, input logic [CW-1:0] d, input logic [CW-1:0] r);
    @(negedge clk);
    meas_valid = 1'b1; count_up = u; count_down = d; count_rundown = r;
    @(negedge clk);
    meas_valid = 1'b0;
    model_capture(u, d, r);
  endtask

  task automatic cs_low();
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Host samples MISO at each SCK rise; called at a negedge of clk.
  task automatic clock_bits(input int n, output logic [127:0] d, output int oe_cnt);
    d = '0;
    oe_cnt = 0;
    for (int i = 0; i < n; i++) begin
      spi_sck = 1'b1;
      d = {d[126:0], spi_miso};
      if (spi_miso_oe) oe_cnt++;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic read_frame(input int n, output logic [127:0] d, output int oe_cnt);
    cs_low();
    clock_bits(n, d, oe_cnt);
    cs_high();
  endtask

  typedef struct {
    bit            rst;
    int            ncap;
    logic [CW-1:0] up, dn, rd;
    logic [FB-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [127:0]  d;
    logic [FB-1:0] exp, exp_old;
    int            oe_cnt;

    tbl[0] = '{1'b1, 1, 24'h000100, 24'h0000F0, 24'h00ABCD, 88'h00_00_000100_0000F0_00ABCD};
    tbl[1] = '{1'b1, 2, 24'h000001, 24'h000002, 24'h000003, 88'h01_80_000001_000002_000003};
    tbl[2] = '{1'b0, 1, 24'h000010, 24'h000020, 24'h000030, 88'h02_00_000010_000020_000030};
    tbl[3] = '{1'b0, 1, 24'h000005, 24'h000006, 24'hFFFFFF, 88'h03_40_000005_000006_FFFFFF};
    tbl[4] = '{1'b0, 1, 24'hFFFFFF, 24'h000000, 24'h000000, 88'h04_40_FFFFFF_000000_000000};
    tbl[5] = '{1'b0, 2, 24'hFFFFFF, 24'h000007, 24'h000008, 88'h06_C0_FFFFFF_000007_000008};

    model_reset();
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("reset_miso", 128'(spi_miso), 128'(0));
    check("reset_oe", 128'(spi_miso_oe), 128'(0));
    check("reset_ready", 128'(data_ready), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Fixed vectors
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      for (int c = 0; c < tbl[i].ncap - 1; c++) capture(24'h111111, 24'h111111, 24'h111111);
      capture(tbl[i].up, tbl[i].dn, tbl[i].rd);
      check($sformatf("tbl%0d_ready_before", i), 128'(data_ready), 128'(1));
      read_frame(FB, d, oe_cnt);
      model_read();
      check($sformatf("tbl%0d_frame", i), 128'(d[FB-1:0]), 128'(tbl[i].exp));
      check($sformatf("tbl%0d_oe_during", i), 128'(oe_cnt), 128'(FB));
      check($sformatf("tbl%0d_oe_after", i), 128'(spi_miso_oe), 128'(0));
      check($sformatf("tbl%0d_ready_after", i), 128'(data_ready), 128'(0));
    end

    // Randomized captures and reads against the model
    do_reset();
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int c = 0; c < n; c++) capture(rnd_count(), rnd_count(), rnd_count());
      check($sformatf("rnd%0d_ready", it), 128'(data_ready), 128'(m_ready));
      exp = model_frame();
      read_frame(FB, d, oe_cnt);
      model_read();
      check($sformatf("rnd%0d_frame", it), 128'(d[FB-1:0]), 128'(exp));
    end

    // Sequence number wrap: 257th capture after reset carries seq 0
    do_reset();
    for (int k = 0; k < 256; k++) capture(CW'(k), CW'(k + 1), CW'(k + 2));
    capture(24'h00000A, 24'h00000B, 24'h00000C);
    exp = model_frame();
    read_frame(FB, d, oe_cnt);
    model_read();
    check("wrap_frame", 128'(d[FB-1:0]), 128'(exp));
    check("wrap_seq", 128'(d[87:80]), 128'(8'h00));
    check("wrap_status", 128'(d[79:72]), 128'(8'h80));

    // Capture landing in the LOAD cycle
    capture(24'h0AAAAA, 24'h0BBBBB, 24'h0CCCCC);
    exp_old = model_frame();
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
    meas_valid = 1'b1; count_up = 24'h000111; count_down = 24'h000222; count_rundown = 24'h000333;
    @(negedge clk) meas_valid = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(FB, d, oe_cnt);
    cs_high();
    model_read();
    model_capture(24'h000111, 24'h000222, 24'h000333);
    check("collide_old_frame", 128'(d[FB-1:0]), 128'(exp_old));
    check("collide_ready_kept", 128'(data_ready), 128'(1));
    exp = model_frame();
    read_frame(FB, d, oe_cnt);
    model_read();
    check("collide_new_frame", 128'(d[FB-1:0]), 128'(exp));
    check("collide_no_overrun", 128'(d[79]), 128'(0));

    // Abort after 20 bits, then an over-clocked full read
    capture(24'h123456, 24'h654321, 24'h0F0F0F);
    exp = model_frame();
    cs_low();
    clock_bits(20, d, oe_cnt);
    spi_cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    model_read();
    check("abort_oe_low", 128'(spi_miso_oe), 128'(0));
    check("abort_bits", 128'(d[19:0]), 128'(exp[FB-1:FB-20]));
    check("abort_ready", 128'(data_ready), 128'(0));
    repeat (8) @(negedge clk);
    exp = model_frame();
    read_frame(100, d, oe_cnt);
    model_read();
    check("over_frame", 128'(d[99:12]), 128'(exp));
    check("over_tail_zero", 128'(d[11:0]), 128'(0));
    check("over_oe", 128'(oe_cnt), 128'(100));

    // Reset in the middle of a shift with cs_n held low
    capture(24'hABCDEF, 24'h000042, 24'h777777);
    cs_low();
    clock_bits(10, d, oe_cnt);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_miso", 128'(spi_miso), 128'(0));
    check("midrst_oe", 128'(spi_miso_oe), 128'(0));
    check("midrst_ready", 128'(data_ready), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    clock_bits(6, d, oe_cnt);
    check("midrst_no_drive", 128'(oe_cnt), 128'(0));
    check("midrst_no_data", 128'(d[5:0]), 128'(0));
    cs_high();
    exp = model_frame();
    read_frame(FB, d, oe_cnt);
    model_read();
    check("midrst_fresh_frame", 128'(d[FB-1:0]), 128'(exp));
    check("midrst_fresh_oe", 128'(oe_cnt), 128'(FB));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_result_spi.md
Name: adc_result_spi

Overview:
- Downstream of the multi-slope integrator controller.
- Captures each completed conversion: run-up positive count, run-up negative count and rundown count, qualified by a one-cycle done strobe.
- Stamps each capture with a sequence number and status byte, and holds it in a result register.
- Serves the result to the host MCU through an SPI mode-0 slave, with a data_ready line for interrupting the host.

Parameters:
- CW, 24, width of each count field.
- SYNC_STAGES, 2, flip-flop stages synchronising spi_sck and spi_cs_n into clk.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst_n  in  1  reset, asynchronous, active-low.
- meas_valid  in  1  one-cycle strobe; count inputs valid this cycle.
- count_up  in  CW  run-up cycles with the positive reference.
- count_down  in  CW  run-up cycles with the negative reference.
- count_rundown  in  CW  rundown clocks until zero-cross.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active-low, asynchronous.
- spi_miso  out  1  serial data, MSB first.
- spi_miso_oe  out  1  output enable for the MISO pad; high while selected.
- data_ready  out  1  high while an unread result is held.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, data_ready=0, seq=0, overrun=0. Holding register, shift register and bit counter are all cleared.
- Frame layout: FRAME_BITS = 16 + 3*CW (88 at default). Order is {seq[7:0], status[7:0], count_up, count_down, count_rundown}, sent MSB first.
- Status byte: bit7 = overrun. bit6 = saturate, set when any count field captured as all-ones. Bits 5:0 are 0.
- Capture: on meas_valid the holding register latches the three counts and the current seq.
  - seq increments after each capture and wraps 255 -> 0.
  - data_ready <= 1.
  - If data_ready was already 1, overrun <= 1 (sticky).
- Synchronisation: spi_sck and spi_cs_n pass through SYNC_STAGES flops plus one extra flop for edge detection.
  - Edges are detected SYNC_STAGES+1 clk after the pin transition.
  - Host requirement: SCK half-period >= 4 clk.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: spi_miso_oe=0. A falling edge on the synchronised cs_n moves to LOAD.
  - LOAD (exactly 1 clk): shift register <= holding frame, including the current overrun bit. Clears data_ready and overrun, bit_cnt <= 0, spi_miso_oe <= 1, spi_miso <= frame MSB. Next state is SHIFT.
  - SHIFT:
    - Synchronised sck rise increments bit_cnt.
    - Synchronised sck fall shifts left, inserting 0; spi_miso follows the new MSB.
    - After FRAME_BITS bits have been sent, further clocks shift out zeros, and bit_cnt saturates at FRAME_BITS.
  - A rise on synchronised cs_n in SHIFT or LOAD returns to IDLE the next clk with spi_miso_oe=0. This is an abort; the already-cleared data_ready is not restored.
- Simultaneous meas_valid and LOAD:
  - LOAD takes the old holding contents.
  - The new capture then writes holding, and data_ready ends at 1 (set wins over clear).
  - overrun is not set, because the old result is being read.
- meas_valid during SHIFT captures into holding without disturbing the frame being shifted.
- Reset mid-transfer: everything returns to reset values immediately, and the FSM is in IDLE. If cs_n is still low at reset release, no LOAD occurs until a fresh falling edge.

Decomposition:
- Shared package adc_pkg:
  - Constants CW_DEFAULT, FRAME_BITS, STATUS_OVERRUN_BIT=7, STATUS_SAT_BIT=6.
  - FSM state encoding for IDLE/LOAD/SHIFT.
- Sub-module spi_sync_edge:
  - SYNC_STAGES synchroniser plus edge detector, outputting level, rise and fall.
  - Instanced once each for sck and cs_n.

Test Plan:
- Reset, then one meas_valid with up=0x000100, down=0x0000F0, rundown=0x00ABCD, then an 88-bit SPI read -> frame 0x00_00_000100_0000F0_00ABCD. data_ready 1 -> 0 at LOAD. spi_miso_oe high only while selected.
- Two meas_valid without a read, second with up=1, down=2, rundown=3 -> frame seq=0x01, status=0x80, counts 1/2/3. A following capture and read -> status=0x00.
- count_rundown=0xFFFFFF -> status bit6 set. 256 captures -> seq wraps: the 257th capture carries seq=0x00.
- meas_valid asserted in the same clk as LOAD -> read returns the previous result, and data_ready stays 1 afterwards. A second read returns the new result with overrun=0.
- cs_n raised after 20 bits -> spi_miso_oe low within SYNC_STAGES+2 clk, and data_ready remains 0. Clocking 100 bits in a full read -> bits 89-100 are 0.
- rst_n pulsed low mid-SHIFT with cs_n held low -> outputs at reset values, and no frame is driven until cs_n toggles high then low.
